div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the 64-bit iterative radix-2 divider (V_Div-style: in_valid/in_a/in_b/div_signed/flush in; result_valid/quotient/remainder out).
- Accepts RV64M DIV/DIVU/REM/REMU and their W forms over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow without using the divider.
- Otherwise launches the divider, holds its operands stable for the whole run, selects and sign-extends the result, and holds that result until it is consumed. Pipeline flush cancels any in-flight operation.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, width of the watchdog cycle counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (high only in IDLE).
- req_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- req_word  input  1  W variant (32-bit operation).
- req_a  input  XLEN  dividend (rs1).
- req_b  input  XLEN  divisor (rs2).
- flush  input  1  pipeline flush.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  XLEN  final rd value.
- div_in_valid  output  1  start pulse to the divider.
- div_a  output  XLEN  divider dividend; registered and held.
- div_b  output  XLEN  divider divisor; registered and held.
- div_signed  output  1  signed mode to the divider.
- div_flush  output  1  abort to the divider.
- div_result_valid  input  1  divider done strobe.
- div_quotient  input  XLEN  divider quotient.
- div_remainder  input  XLEN  divider remainder.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_data=0, div_in_valid=0, div_a=0, div_b=0, div_signed=0, div_flush=0, busy=0.
  - Watchdog counter = 0.
- States: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - Accept on req_valid&&req_ready. Latch the op, word and signed flags, where signed = ~req_op[0].
  - Operand prep: word signed → sign-extend bits [31:0]; word unsigned → zero-extend [31:0]; otherwise pass through.
  - Special cases are computed on the prepared operands; the result register is written and the next state is DONE, so latency is 1 cycle.
  - b==0: quotient = all ones; remainder = a.
  - signed && a==most-negative && b==all ones: quotient = a; remainder = 0. "Most-negative" is 0x8000_0000_0000_0000 for 64-bit ops, or 0xFFFF_FFFF_8000_0000 after sign-extension for W ops.
  - Otherwise: load div_a/div_b/div_signed and go to LAUNCH.
- LAUNCH: div_in_valid=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - div_a, div_b and div_signed stay constant until DONE is entered. The divider sign-corrects from its live inputs, so this is mandatory.
  - On div_result_valid: select the quotient (op[1]=0) or the remainder (op[1]=1).
  - If word: rsp_data = sign-extend of the selected value's [31:0]; otherwise the full value. Go to DONE.
  - Normal path: the response appears 67-68 cycles after acceptance, 3 of which are controller overhead.
- DONE:
  - rsp_valid=1 and rsp_data stay stable while rsp_ready=0.
  - On rsp_ready: go to IDLE. There is no back-to-back accept in the same cycle; req_ready is low in DONE.
- flush (synchronous, highest priority):
  - In any state, go to IDLE next cycle. rsp_valid drops and no response is emitted.
  - If state is LAUNCH or WAIT, div_flush=1 for one cycle.
  - Flush in the same cycle as req_valid in IDLE: the request is not accepted.
  - Flush in the same cycle as div_result_valid: the result is discarded.
- Watchdog:
  - The counter increments in WAIT and clears on entering WAIT.
  - If it saturates at 2^CNT_W-1 without div_result_valid: pulse div_flush, go to LAUNCH, and relaunch with the held operands.
- div_result_valid outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to the reset values above.

Test Plan:
- DIV a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 → rsp_data=0xFFFF_FFFF_FFFF_FFFD. REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF. Check that div_a/div_b are stable throughout WAIT.
- DIVU a=5, b=0 → rsp_data=0xFFFF_FFFF_FFFF_FFFF one cycle after accept, with no div_in_valid. REMU a=5, b=0 → 5.
- DIV a=0x8000_0000_0000_0000, b=-1 → rsp_data=0x8000_0000_0000_0000, REM → 0, both via the special path. DIVW a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- DIVUW a=0x1_FFFF_FFFE, b=2 → 0x0000_0000_7FFF_FFFF, sign-extended from bit 31 (which is 0). REMW a=-7, b=3 → 0xFFFF_FFFF_FFFF_FFFF.
- rsp_ready held low for 10 cycles after rsp_valid rises → rsp_valid and rsp_data stable and req_ready=0. Then pulse rsp_ready → IDLE next cycle.
- flush asserted 20 cycles into WAIT → div_flush pulses once, state returns to IDLE, and no rsp_valid. A following request DIVU 100/7 → 14.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencing controller between the execute stage and a 64-bit iterative divider.
// Resolves divide-by-zero and signed overflow locally; otherwise launches, waits and formats.
module div_ctrl #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [1:0]      req_op_i,
   input  logic            req_word_i,
   input  logic [XLEN-1:0] req_a_i,
   input  logic [XLEN-1:0] req_b_i,
   input  logic            flush_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_data_o,
   output logic            div_in_valid_o,
   output logic [XLEN-1:0] div_a_o,
   output logic [XLEN-1:0] div_b_o,
   output logic            div_signed_o,
   output logic            div_flush_o,
   input  logic            div_result_valid_i,
   input  logic [XLEN-1:0] div_quotient_i,
   input  logic [XLEN-1:0] div_remainder_i,
   output logic            busy_o
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLaunch = 2'd1;
   localparam logic [1:0] StWait   = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]      state_q, state_d;
   logic            rem_q, rem_d;
   logic            word_q, word_d;
   logic [XLEN-1:0] div_a_q, div_a_d;
   logic [XLEN-1:0] div_b_q, div_b_d;
   logic            div_signed_q, div_signed_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            req_signed;
   logic [XLEN-1:0] a_prep, b_prep, min_neg;
   logic            div_zero, overflow;
   logic [XLEN-1:0] spec_q, spec_r;

   // W results are always the sign-extension of the low word.
   function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] val, input logic word);
      return word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
   endfunction

   always_comb begin
      req_signed = ~req_op_i[0];
      a_prep     = req_a_i;
      b_prep     = req_b_i;
      if (req_word_i) begin
         if (req_signed) begin
            a_prep = {{(XLEN-32){req_a_i[31]}}, req_a_i[31:0]};
            b_prep = {{(XLEN-32){req_b_i[31]}}, req_b_i[31:0]};
         end else begin
            a_prep = {{(XLEN-32){1'b0}}, req_a_i[31:0]};
            b_prep = {{(XLEN-32){1'b0}}, req_b_i[31:0]};
         end
      end
      min_neg  = req_word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
      div_zero = (b_prep == '0);
      overflow = req_signed && (a_prep == min_neg) && (b_prep == '1);
      spec_q   = div_zero ? '1 : a_prep;
      spec_r   = div_zero ? a_prep : '0;
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      word_d       = word_q;
      div_a_d      = div_a_q;
      div_b_d      = div_b_q;
      div_signed_d = div_signed_q;
      rsp_data_d   = rsp_data_q;
      cnt_d        = cnt_q;
      div_flush_o  = 1'b0;
      if (flush_i) begin
         state_d     = StIdle;
         div_flush_o = (state_q == StLaunch) || (state_q == StWait);
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  rem_d  = req_op_i[1];
                  word_d = req_word_i;
                  if (div_zero || overflow) begin
                     rsp_data_d = fmt_result(req_op_i[1] ? spec_r : spec_q, req_word_i);
                     state_d    = StDone;
                  end else begin
                     div_a_d      = a_prep;
                     div_b_d      = b_prep;
                     div_signed_d = req_signed;
                     state_d      = StLaunch;
                  end
               end
            end
            StLaunch: begin
               cnt_d   = '0;
               state_d = StWait;
            end
            StWait: begin
               if (div_result_valid_i) begin
                  rsp_data_d = fmt_result(rem_q ? div_remainder_i : div_quotient_i, word_q);
                  state_d    = StDone;
               end else if (cnt_q == '1) begin
                  // Divider looks hung: abort it and relaunch with the held operands.
                  div_flush_o = 1'b1;
                  state_d     = StLaunch;
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            default: begin
               if (rsp_ready_i) state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         rem_q        <= 1'b0;
         word_q       <= 1'b0;
         div_a_q      <= '0;
         div_b_q      <= '0;
         div_signed_q <= 1'b0;
         rsp_data_q   <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         word_q       <= word_d;
         div_a_q      <= div_a_d;
         div_b_q      <= div_b_d;
         div_signed_q <= div_signed_d;
         rsp_data_q   <= rsp_data_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready_o    = (state_q == StIdle);
   assign rsp_valid_o    = (state_q == StDone);
   assign rsp_data_o     = rsp_data_q;
   assign div_in_valid_o = (state_q == StLaunch);
   assign div_a_o        = div_a_q;
   assign div_b_o        = div_b_q;
   assign div_signed_o   = div_signed_q;
   assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed vector table, random ops against an arithmetic reference,
// and hand sequences for hold, flush, watchdog and reset corner cases.
module tb_div_ctrl;

   localparam int DIV_LAT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_word = 1'b0, flush = 1'b0;
   logic [1:0]  req_op = 2'b00;
   logic [63:0] req_a = '0, req_b = '0;
   logic        rsp_valid, rsp_ready = 1'b0;
   logic [63:0] rsp_data;
   logic        div_in_valid, div_signed, div_flush, busy;
   logic [63:0] div_a, div_b;
   logic        div_result_valid = 1'b0;
   logic [63:0] div_quotient = '0, div_remainder = '0;

   int n_chk = 0, n_fail = 0, wd_pulses = 0;
   int m_cnt = 0;
   bit m_drop = 0, drop_next = 0;

   always #5 clk = ~clk;

   div_ctrl #(.XLEN(64), .CNT_W(7)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_word_i(req_word), .req_a_i(req_a), .req_b_i(req_b), .flush_i(flush),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .div_in_valid_o(div_in_valid), .div_a_o(div_a), .div_b_o(div_b),
      .div_signed_o(div_signed), .div_flush_o(div_flush),
      .div_result_valid_i(div_result_valid), .div_quotient_i(div_quotient),
      .div_remainder_i(div_remainder), .busy_o(busy)
   );

   // Divider model: answers DIV_LAT cycles after launch from its live inputs.
   always @(negedge clk) begin
      logic signed [63:0] sa, sb;
      if (!rst_n) begin
         m_cnt = 0;
         m_drop = 0;
         div_result_valid = 1'b0;
      end else begin
         div_result_valid = 1'b0;
         if (div_flush) begin
            m_cnt = 0;
         end else if (div_in_valid) begin
            m_cnt = DIV_LAT;
            m_drop = drop_next;
            drop_next = 0;
         end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0 && !m_drop && div_b != '0) begin
               sa = div_a;
               sb = div_b;
               div_quotient  = div_signed ? 64'(sa / sb) : div_a / div_b;
               div_remainder = div_signed ? 64'(sa % sb) : div_a % div_b;
               div_result_valid = 1'b1;
            end
         end
      end
   end

   function automatic logic [63:0] ref_rd(input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
      logic sgn;
      logic [31:0] a32, b32, q32, r32, s32;
      logic signed [31:0] sa32, sb32;
      logic [63:0] q64, r64;
      logic signed [63:0] sa64, sb64;
      sgn = ~op[0];
      if (word) begin
         a32 = a[31:0];
         b32 = b[31:0];
         sa32 = a32;
         sb32 = b32;
         if (b32 == 0) begin
            q32 = '1; r32 = a32;
         end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
            q32 = a32; r32 = 0;
         end else if (sgn) begin
            q32 = 32'(sa32 / sb32); r32 = 32'(sa32 % sb32);
         end else begin
            q32 = a32 / b32; r32 = a32 % b32;
         end
         s32 = op[1] ? r32 : q32;
         return {{32{s32[31]}}, s32};
      end
      sa64 = a;
      sb64 = b;
      if (b == 0) begin
         q64 = '1; r64 = a;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
         q64 = a; r64 = 0;
      end else if (sgn) begin
         q64 = 64'(sa64 / sb64); r64 = 64'(sa64 % sb64);
      end else begin
         q64 = a / b; r64 = a % b;
      end
      return op[1] ? r64 : q64;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_op(input string name, input logic [1:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input int hold,
                        output logic [63:0] rd, output int lat, output int launches);
      logic [63:0] la, lb;
      logic ls;
      bit launched, stable, got, ok;
      launched = 0; stable = 1; got = 0; ok = 1; lat = 0; launches = 0;
      la = '0; lb = '0; ls = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; req_word = word; req_a = a; req_b = b;
      @(posedge clk); #1;
      req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         lat++;
         if (div_in_valid) begin
            launches++;
            launched = 1;
            la = div_a; lb = div_b; ls = div_signed;
         end else if (launched && !rsp_valid && (div_a !== la || div_b !== lb || div_signed !== ls))
            stable = 0;
         if (div_flush && !flush) wd_pulses++;
         if (rsp_valid) begin
            got = 1;
            break;
         end
      end
      check({name, " rsp_valid seen"}, 64'(got), 64'd1);
      check({name, " operands held"}, 64'(stable), 64'd1);
      rd = rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_data !== rd || req_ready) ok = 0;
      end
      check({name, " held while stalled"}, 64'(ok), 64'd1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      check({name, " back to idle"}, {61'd0, rsp_valid, req_ready, busy}, 64'b010);
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      bit          special;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [63:0] rd;
      int lat, launches, pulses, sel;
      logic [1:0] op;
      logic word;
      logic [63:0] a, b;
      bit seen;

      vecs[0] = '{"div -7/2",      2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, 0};
      vecs[1] = '{"rem -7/2",      2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[2] = '{"divu 5/0",      2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      vecs[3] = '{"remu 5/0",      2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1};
      vecs[4] = '{"div ovf",       2'b00, 1'b0, 64'h8000_0000_0000_0000, '1,
                  64'h8000_0000_0000_0000, 1};
      vecs[5] = '{"rem ovf",       2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
      vecs[6] = '{"divw ovf",      2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 1};
      vecs[7] = '{"divuw",         2'b01, 1'b1, 64'h1_FFFF_FFFE, 64'd2, 64'h7FFF_FFFF, 0};
      vecs[8] = '{"remw -7/3",     2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3,
                  64'hFFFF_FFFF_FFFF_FFFF, 0};
      vecs[9] = '{"divu 100/7",    2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 0};

      #3;
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_data", rsp_data, 64'd0);
      check("reset div outs", {div_a | div_b, 60'd0, div_in_valid, div_signed, div_flush, busy},
            128'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].name, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, 0,
               rd, lat, launches);
         check({vecs[i].name, " data"}, rd, vecs[i].exp);
         if (vecs[i].special) check({vecs[i].name, " 1-cycle no launch"},
                                    {32'(lat), 32'(launches)}, {32'd1, 32'd0});
      end

      // Stalled consumer for 10 cycles.
      do_op("stall div 1000/9", 2'b00, 1'b0, 64'd1000, 64'd9, 10, rd, lat, launches);
      check("stall div data", rd, 64'd111);

      // Flush 20 cycles into WAIT.
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b01; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd3;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (22) @(posedge clk);
      #1 flush = 1'b1;
      pulses = 0; seen = 0;
      @(negedge clk);
      if (div_flush) pulses++;
      @(posedge clk); #1 flush = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (div_flush) pulses++;
         if (rsp_valid || busy) seen = 1;
      end
      check("flush div_flush pulses", 64'(pulses), 64'd1);
      check("flush no response", 64'(seen), 64'd0);
      do_op("after flush divu 100/7", 2'b01, 1'b0, 64'd100, 64'd7, 0, rd, lat, launches);
      check("after flush data", rd, 64'd14);

      // Flush coincident with a request in IDLE: not accepted.
      @(posedge clk); #1;
      req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_a = 64'd50; req_b = 64'd5;
      @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush+req idle", {62'd0, busy, div_in_valid}, 64'd0);

      // Watchdog: the divider swallows the first launch.
      wd_pulses = 0;
      @(posedge clk); #1 drop_next = 1;
      do_op("watchdog", 2'b10, 1'b0, 64'd12345, 64'd100, 0, rd, lat, launches);
      check("watchdog data", rd, 64'd45);
      check("watchdog relaunch", {32'(launches), 32'(wd_pulses)}, {32'd2, 32'd1});

      // Random ops against the arithmetic reference.
      for (int n = 0; n < 30; n++) begin
         op = 2'($urandom_range(0, 3));
         word = 1'($urandom_range(0, 1));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         sel = $urandom_range(0, 7);
         if (sel == 0) b = word ? {$urandom, 32'd0} : 64'd0;
         else if (sel == 1) begin
            b = '1;
            a = word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
         end else if (sel == 2) b = 64'($urandom_range(1, 20));
         do_op("random", op, word, a, b, $urandom_range(0, 3), rd, lat, launches);
         check($sformatf("random op%0d w%0d a=%h b=%h", op, word, a, b), rd,
               ref_rd(op, word, a, b));
      end

      // Asynchronous reset mid-operation.
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 2'b00; req_word = 1'b0; req_a = 64'd777; req_b = 64'd5;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midop reset div_a/b", div_a | div_b, 64'd0);
      check("midop reset rsp_data", rsp_data, 64'd0);
      check("midop reset flags", {60'd0, req_ready, busy, div_in_valid, rsp_valid}, 64'b1000);
      @(posedge clk); #1 rst_n = 1'b1;
      do_op("post reset div", 2'b00, 1'b0, 64'd777, 64'd5, 0, rd, lat, launches);
      check("post reset data", rd, 64'd155);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
